// File: rtl/mem_pkg.sv
// Shared types and widths for the data memory responder and its storage.
package mem_pkg;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } mem_state_t;
endpackage

// File: rtl/sp_ram_be.sv
// Single-port word RAM with per-byte write enables; synchronous write, combinational read.
module sp_ram_be
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  // No reset: contents survive a responder reset.
  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding CPU data memory responder with fixed, parameterised access latency.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH * 4);
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  mem_state_t state, state_nxt;
  logic [3:0]        cnt;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [WORD_W-1:0] lat_wdata;
  logic [BE_W-1:0]   lat_be;

  logic              hs, go_resp, acc_err, ram_we;
  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [WORD_W-1:0] acc_wdata, ram_rdata;
  logic [BE_W-1:0]   acc_be;

  assign hs = req_valid & req_ready;

  // With zero wait cycles RESP is entered on the handshake edge itself, so the
  // access must use the live request rather than the not-yet-latched copy.
  assign acc_we    = (state == ST_IDLE) ? req_we    : lat_we;
  assign acc_addr  = (state == ST_IDLE) ? req_addr  : lat_addr;
  assign acc_wdata = (state == ST_IDLE) ? req_wdata : lat_wdata;
  assign acc_be    = (state == ST_IDLE) ? req_be    : lat_be;

  assign acc_err = ({1'b0, acc_addr} >= LIMIT) || (acc_addr[1:0] != 2'b00) || (acc_be == '0);
  assign go_resp = (state != ST_RESP) && (state_nxt == ST_RESP);
  assign ram_we  = go_resp && acc_we && !acc_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (hs) state_nxt = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (cnt == 4'd0) state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == ST_IDLE);
    rsp_valid = (state == ST_RESP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (hs) begin
        cnt       <= CNT_LOAD;
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_be    <= req_be;
      end else if (state == ST_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end

      if (go_resp) begin
        rsp_err   <= acc_err;
        rsp_rdata <= (acc_err || acc_we) ? '0 : ram_rdata;
      end else if (state == ST_RESP && rsp_ready) begin
        rsp_err   <= 1'b0;
        rsp_rdata <= '0;
      end
    end
  end

  sp_ram_be #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .be    (acc_be),
    .addr  (acc_addr[AW+1:2]),
    .wdata (acc_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: DUT a (DEPTH 256, 2 wait cycles) and DUT b (DEPTH 16, no wait cycles).
module tb_data_mem_responder;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  logic [3:0]  a_req_be;
  logic b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
  logic [3:0]  b_req_be;

  int checks = 0;
  int errors = 0;

  data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(2), .ADDR_W(32)) dut_a (
    .clk(clk), .reset(reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
  );

  data_mem_responder #(.DEPTH(16), .WAIT_CYCLES(0), .ADDR_W(32)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One DUT-a transaction with rsp_ready held high; lat counts cycles from handshake to rsp_valid.
  task automatic a_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, output int lat, output logic [31:0] rdata,
                       output logic err);
    int n;
    a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr; a_req_wdata = wdata; a_req_be = be;
    a_rsp_ready = 1'b1;
    step();
    a_req_valid = 1'b0;
    n = 1;
    while (!a_rsp_valid && n < 20) begin
      step();
      n++;
    end
    lat = n; rdata = a_rsp_rdata; err = a_rsp_err;
    step();
  endtask

  initial begin
    int lat;
    logic [31:0] rd;
    logic er;

    a_req_valid = 0; a_req_we = 0; a_req_addr = '0; a_req_wdata = '0; a_req_be = '0; a_rsp_ready = 1;
    b_req_valid = 0; b_req_we = 0; b_req_addr = '0; b_req_wdata = '0; b_req_be = '0; b_rsp_ready = 1;

    #2;
    chk("rst_req_ready", {31'd0, a_req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
    chk("rst_rsp_err",   {31'd0, a_rsp_err},   32'd0);
    chk("rst_rsp_rdata", a_rsp_rdata,          32'd0);
    step(); step();
    reset = 1'b1;
    step();

    // DUT b: requests held valid continuously, responses every other cycle.
    b_req_valid = 1; b_req_we = 1; b_req_addr = 32'h0; b_req_wdata = 32'hA5A5A5A5; b_req_be = 4'hF;
    step();
    chk("b_st0_valid", {31'd0, b_rsp_valid}, 32'd1);
    chk("b_st0_ready", {31'd0, b_req_ready}, 32'd0);
    b_req_addr = 32'h4; b_req_wdata = 32'h3C3C3C3C;
    step();
    chk("b_gap1", {31'd0, b_rsp_valid}, 32'd0);
    step();
    chk("b_st1_valid", {31'd0, b_rsp_valid}, 32'd1);
    b_req_we = 0; b_req_addr = 32'h0;
    step();
    chk("b_gap2", {31'd0, b_rsp_valid}, 32'd0);
    step();
    chk("b_ld0_valid", {31'd0, b_rsp_valid}, 32'd1);
    chk("b_ld0_rdata", b_rsp_rdata, 32'hA5A5A5A5);
    b_req_addr = 32'h4;
    step();
    chk("b_gap3", {31'd0, b_rsp_valid}, 32'd0);
    step();
    chk("b_ld1_valid", {31'd0, b_rsp_valid}, 32'd1);
    chk("b_ld1_rdata", b_rsp_rdata, 32'h3C3C3C3C);
    b_req_addr = 32'h40;
    step();
    step();
    chk("b_oor_err",   {31'd0, b_rsp_err}, 32'd1);
    chk("b_oor_rdata", b_rsp_rdata, 32'd0);
    b_req_valid = 0;
    step();

    // DUT a: full store/load, partial store, error cases.
    a_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, rd, er);
    chk("st_lat", lat, 32'd3); chk("st_rdata", rd, 32'd0); chk("st_err", {31'd0, er}, 32'd0);
    a_txn(1'b0, 32'h10, 32'h0, 4'hF, lat, rd, er);
    chk("ld_lat", lat, 32'd3); chk("ld_rdata", rd, 32'hDEADBEEF); chk("ld_err", {31'd0, er}, 32'd0);
    a_txn(1'b1, 32'h10, 32'h11112222, 4'h3, lat, rd, er);
    chk("pst_err", {31'd0, er}, 32'd0);
    a_txn(1'b0, 32'h10, 32'h0, 4'h1, lat, rd, er);
    chk("pld_rdata", rd, 32'hDEAD2222);
    a_txn(1'b0, 32'h402, 32'h0, 4'hF, lat, rd, er);
    chk("mis_err", {31'd0, er}, 32'd1); chk("mis_rdata", rd, 32'd0);
    a_txn(1'b0, 32'h400, 32'h0, 4'hF, lat, rd, er);
    chk("oor_err", {31'd0, er}, 32'd1); chk("oor_rdata", rd, 32'd0);
    a_txn(1'b1, 32'h10, 32'h0, 4'h0, lat, rd, er);
    chk("be0_err", {31'd0, er}, 32'd1);
    a_txn(1'b1, 32'h12, 32'h0, 4'hF, lat, rd, er);
    chk("mis_st_err", {31'd0, er}, 32'd1);
    a_txn(1'b0, 32'h10, 32'h0, 4'hF, lat, rd, er);
    chk("post_err_rdata", rd, 32'hDEAD2222);

    // Stall in RESP with another request waiting; nothing may be accepted.
    a_rsp_ready = 0;
    a_req_valid = 1; a_req_we = 0; a_req_addr = 32'h10; a_req_be = 4'hF;
    step();
    a_req_addr = 32'h0;
    step(); step();
    chk("stall_lat", {31'd0, a_rsp_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", {31'd0, a_rsp_valid}, 32'd1);
      chk("stall_rdata", a_rsp_rdata, 32'hDEAD2222);
      chk("stall_ready", {31'd0, a_req_ready}, 32'd0);
    end
    a_rsp_ready = 1;
    step();
    chk("rel_valid", {31'd0, a_rsp_valid}, 32'd0);
    chk("rel_ready", {31'd0, a_req_ready}, 32'd1);
    a_req_valid = 0;
    step(); step(); step(); step();
    chk("no_phantom", {31'd0, a_rsp_valid}, 32'd0);

    // Reset during WAIT of a store must leave memory untouched.
    a_txn(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, lat, rd, er);
    a_req_valid = 1; a_req_we = 1; a_req_addr = 32'h20; a_req_wdata = 32'h55555555; a_req_be = 4'hF;
    step();
    a_req_valid = 0;
    chk("wait_ready", {31'd0, a_req_ready}, 32'd0);
    #1 reset = 1'b0;
    #1;
    chk("mrst_ready", {31'd0, a_req_ready}, 32'd1);
    chk("mrst_valid", {31'd0, a_rsp_valid}, 32'd0);
    chk("mrst_err",   {31'd0, a_rsp_err},   32'd0);
    step(); step();
    reset = 1'b1;
    step(); step(); step();
    chk("mrst_abandon", {31'd0, a_rsp_valid}, 32'd0);
    a_txn(1'b0, 32'h20, 32'h0, 4'hF, lat, rd, er);
    chk("mrst_mem", rd, 32'hCAFEF00D);
    chk("mrst_lat", lat, 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, memory size in 32-bit words (power of two, min 4).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, added access latency in cycles (0..15).
REQ-003 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  1  CPU request present.
REQ-007 req_ready  output  1  responder accepts request this cycle.
REQ-008 req_we  input  1  1=store, 0=load.
REQ-009 req_addr  input  ADDR_W  byte address.
REQ-010 req_wdata  input  32  store data.
REQ-011 req_be  input  4  byte enables, bit i = byte lane i.
REQ-012 rsp_valid  output  1  response present.
REQ-013 rsp_ready  input  1  CPU accepts response.
REQ-014 rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-015 rsp_err  output  1  access fault.

Function
REQ-016 SHALL implement FSM IDLE, WAIT, RESP.
REQ-017 IDLE: req_ready=1; handshake = req_valid & req_ready; on handshake latch we/addr/wdata/be, go to WAIT if WAIT_CYCLES>0 else RESP.
REQ-018 WAIT: req_ready=0; down-counter loaded with WAIT_CYCLES-1 at handshake; go to RESP when counter is 0.
REQ-019 Memory access (read or write) SHALL occur on the cycle of entry to RESP, never earlier.
REQ-020 RESP: rsp_valid=1; rsp_rdata/rsp_err SHALL hold stable until rsp_valid & rsp_ready; then return to IDLE.
REQ-021 Latency handshake->rsp_valid SHALL be exactly WAIT_CYCLES+1 cycles.
REQ-022 At most one outstanding request; req_ready=0 in WAIT and RESP (no request accepted in the cycle the response completes).
REQ-023 Word index = addr[log2(DEPTH)+1:2]; addr[1:0] ignored for word access.
REQ-024 Error if addr >= DEPTH*4, or addr[1:0]!=0, or req_be==0; on error: rsp_err=1, rsp_rdata=0, memory unchanged.
REQ-025 Store: only lanes with be[i]=1 written; rsp_rdata=0, rsp_err=0.
REQ-026 Load: full 32-bit word returned regardless of be.
REQ-027 Load after store to same word SHALL return the stored data (no stale reads).
REQ-028 rsp_ready held high before RESP SHALL not shorten latency.

Reset
REQ-029 reset low SHALL asynchronously force: state=IDLE, counter=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, req_ready=1 (combinational from IDLE).
REQ-030 Reset mid-operation SHALL abandon the pending request; a pending store not yet in RESP SHALL not modify memory.
REQ-031 Memory array contents SHALL not be cleared by reset (no reset on array).

Structure
REQ-032 Shared package mem_pkg SHALL hold the FSM state enum (mem_state_t) and WORD_W=32, BE_W=4 constants.
REQ-033 Storage SHALL be one sub-module, sp_ram_be (single-port, byte-enabled, synchronous write, combinational read), instantiated once.
REQ-034 Target RTL size 120-400 lines total.

Verification
REQ-035 Store addr 0x10, wdata 0xDEADBEEF, be 0xF, WAIT_CYCLES=2; then load 0x10 -> rsp_valid 3 cycles after each handshake, rdata 0xDEADBEEF, err 0.
REQ-036 Store 0x10 be 0x3 wdata 0x11112222 over 0xDEADBEEF; load -> 0xDEAD2222.
REQ-037 Load addr 0x402 (misaligned) and 0x400 (DEPTH=256, out of range) -> err 1, rdata 0; follow-up load 0x10 unchanged.
REQ-038 Hold rsp_ready low 5 cycles in RESP -> rsp_valid/rdata stable, req_ready 0 throughout; release -> IDLE next cycle.
REQ-039 Assert reset low during WAIT of store to 0x20 -> outputs cleared immediately; load 0x20 after release returns prior contents.
REQ-040 WAIT_CYCLES=0 back-to-back loads with rsp_ready=1 -> one response per 2 cycles, latency 1.
